decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters: DATA_W, 32, datapath width; REG_AW, 5, register address width; FWD_STAGES, 2, downstream forwarding sources (1..4); IBUF_DEPTH, 4, instruction buffer entries (power of 2, >=2); BR_SHIFT, 0, left shift applied to the sign-extended branch offset (0 or 2).
REQ-002 Ports (name dir width meaning): clk in 1 clock; reset in 1 synchronous active-high reset (one clock; reset is synchronous and active-high).
REQ-003 if_valid in 1 fetch word valid; if_ready out 1 buffer can accept; if_pc in DATA_W fetch PC; if_insn in DATA_W fetch instruction.
REQ-004 gpr_rd_addr_0/gpr_rd_addr_1 out REG_AW rs/rt of buffer head; gpr_rd_data_0/gpr_rd_data_1 in DATA_W same-cycle register file data.
REQ-005 fwd_en in FWD_STAGES stage valid; fwd_we_ in FWD_STAGES active-low write enable; fwd_is_load in FWD_STAGES load data not yet available; fwd_addr in FWD_STAGES*REG_AW; fwd_data in FWD_STAGES*DATA_W; index 0 = youngest stage.
REQ-006 ex_stall in 1 downstream hold; flush in 1 discard all decode state.
REQ-007 Outputs, all registered: id_valid 1; id_pc DATA_W; id_alu_op, id_mem_op, id_exp_code per existing ALU/memory/exception encodings; id_alu_in_0, id_alu_in_1, id_mem_wr_data DATA_W; id_dst_addr REG_AW; id_gpr_we_ 1 active-low; id_br_taken 1; id_br_addr DATA_W; ld_hazard 1 (combinational, exempt).

Function
REQ-008 Instruction buffer: IBUF_DEPTH-entry FIFO of {pc, insn}; push when if_valid && if_ready; if_ready = !full (registered count, no combinational path from downstream).
REQ-009 Pop when head valid && !ld_hazard && !ex_stall; push and pop in same cycle leave count unchanged; pointers wrap modulo IBUF_DEPTH.
REQ-010 Latency: word accepted at edge N appears on id_* after edge N+1 when unstalled.
REQ-011 Operand select per rs/rt independently: address 0 yields 0, never forwarded; else lowest index k with fwd_en[k] && !fwd_we_[k] && fwd_addr[k]==addr supplies fwd_data[k]; else gpr_rd_data.
REQ-012 ld_hazard = 1 when the matching source chosen per REQ-011 has fwd_is_load set; an older non-load match never overrides a younger load match.
REQ-013 Decode: R-type ALU, shift (shamt/variable), immediate ALU (signed ADDI/ADDIU, zero-extended ANDI/ORI/XORI), LB/LBU/LH/LHU/LW/SB/SH/SW (address = rs + imm_s, ALU ADDU), BEQ, BNE, BGTZ, BLEZ, BGEZ/BLTZ, J, JAL per existing opcode encodings; every writing instruction asserts id_gpr_we_=0, including shifts and immediates.
REQ-014 Branch: target = pc + (imm_s << BR_SHIFT); BEQ taken iff rs==rt; BNE taken iff rs!=rt; signed compares for others; JAL writes pc+4 to r31.
REQ-015 Undefined opcode/func: id_exp_code = UNDEFINSN, id_gpr_we_=1, id_mem_op=NOP, id_br_taken=0, id_valid=1.
REQ-016 Pipeline register: ex_stall=1 holds all id_* unchanged; else loads decoded head, or a bubble (id_valid=0, id_gpr_we_=1, mem_op NOP, alu_op NOP, br_taken=0, exp_code NOEXP) if buffer empty or ld_hazard.
REQ-017 Taken branch/jump popped at edge N: id_br_taken=1 for that instruction only; all remaining FIFO entries and any word pushed at edge N are discarded; count=0 after edge N.
REQ-018 flush=1: at next edge FIFO empty and id register bubble; flush overrides push, pop, ex_stall and branch.

Reset
REQ-019 reset=1 at edge: FIFO empty, if_ready=1 next cycle, id register bubble (REQ-016 values, id_pc=0, operands=0, id_br_addr=0, id_dst_addr=0).
REQ-020 Reset asserted mid-operation discards buffered and in-flight instructions; no output assumes a value before first reset.

Verification
REQ-021 ADDI r2,r0,5 then ADD r3,r2,r2 with fwd stage0 {en=1,we_=0,addr=2,data=5} -> id_alu_in_0=id_alu_in_1=5, id_dst_addr=3.
REQ-022 stage0 {addr=4,is_load=1}, stage1 {addr=4,data=9}, head uses r4 -> ld_hazard=1, bubble issued, head retained until is_load clears.
REQ-023 Fill IBUF_DEPTH=4 with ex_stall=1 -> if_ready=0 after 4th push; 5th if_valid word not accepted; release stall -> words emerge in order.
REQ-024 BNE r1,r2 (r1=3,r2=3) then BNE (r1=3,r2=4), imm=8, pc=0x100, BR_SHIFT=0 -> first id_br_taken=0; second id_br_taken=1, id_br_addr=0x108, younger entries dropped.
REQ-025 flush and reset asserted with 3 buffered entries and ex_stall=1 -> next cycle id_valid=0, if_ready=1, count 0.
REQ-026 Undefined opcode 0x3F -> id_valid=1, id_exp_code=UNDEFINSN, id_gpr_we_=1.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: instruction buffer, operand forwarding and decode into the
// ID/EX pipeline register.
//   clk, reset            clock, synchronous active-high reset
//   if_valid/if_ready     fetch handshake; if_pc/if_insn fetch word
//   gpr_rd_addr_0/1       rs/rt of the buffer head; gpr_rd_data_0/1 same-cycle data
//   fwd_*                 downstream forwarding sources, index 0 = youngest
//   ex_stall, flush       downstream hold, discard all decode state
//   id_*                  registered decode results; ld_hazard combinational
module decode_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int IBUF_DEPTH = 4,
  parameter int BR_SHIFT   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [DATA_W-1:0]          if_pc,
  input  logic [DATA_W-1:0]          if_insn,
  output logic [REG_AW-1:0]          gpr_rd_addr_0,
  output logic [REG_AW-1:0]          gpr_rd_addr_1,
  input  logic [DATA_W-1:0]          gpr_rd_data_0,
  input  logic [DATA_W-1:0]          gpr_rd_data_1,
  input  logic [FWD_STAGES-1:0]      fwd_en,
  input  logic [FWD_STAGES-1:0]      fwd_we_,
  input  logic [FWD_STAGES-1:0]      fwd_is_load,
  input  logic [FWD_STAGES*REG_AW-1:0] fwd_addr,
  input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
  input  logic                       ex_stall,
  input  logic                       flush,
  output logic                       id_valid,
  output logic [DATA_W-1:0]          id_pc,
  output logic [3:0]                 id_alu_op,
  output logic [3:0]                 id_mem_op,
  output logic [1:0]                 id_exp_code,
  output logic [DATA_W-1:0]          id_alu_in_0,
  output logic [DATA_W-1:0]          id_alu_in_1,
  output logic [DATA_W-1:0]          id_mem_wr_data,
  output logic [REG_AW-1:0]          id_dst_addr,
  output logic                       id_gpr_we_,
  output logic                       id_br_taken,
  output logic [DATA_W-1:0]          id_br_addr,
  output logic                       ld_hazard
);

  localparam int PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [3:0] ALU_NOP = 4'd0,  ALU_ADD = 4'd1,  ALU_ADDU = 4'd2, ALU_SUB = 4'd3,
                         ALU_SUBU = 4'd4, ALU_AND = 4'd5,  ALU_OR = 4'd6,   ALU_XOR = 4'd7,
                         ALU_NOR = 4'd8,  ALU_SLT = 4'd9,  ALU_SLTU = 4'd10, ALU_SLL = 4'd11,
                         ALU_SRL = 4'd12, ALU_SRA = 4'd13;
  localparam logic [3:0] MEM_NOP = 4'd0, MEM_LB = 4'd1, MEM_LBU = 4'd2, MEM_LH = 4'd3,
                         MEM_LHU = 4'd4, MEM_LW = 4'd5, MEM_SB = 4'd6,  MEM_SH = 4'd7,
                         MEM_SW = 4'd8;
  localparam logic [1:0] EXP_NONE = 2'd0, EXP_UNDEFINSN = 2'd1;

  logic [DATA_W-1:0] pc_mem   [IBUF_DEPTH];
  logic [DATA_W-1:0] insn_mem [IBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop, head_valid;
  logic [DATA_W-1:0] head_pc, head_insn;

  assign if_ready   = (count != CNT_W'(IBUF_DEPTH));
  assign head_valid = (count != '0);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_insn  = insn_mem[rd_ptr];
  assign push       = if_valid && if_ready;
  assign pop        = head_valid && !ld_hazard && !ex_stall;

  logic [5:0]        opcode, funct;
  logic [4:0]        rt_f;
  logic [REG_AW-1:0] rs_addr, rt_addr, rd_addr;
  logic [DATA_W-1:0] imm_s, imm_z, shamt, br_tgt, j_tgt;

  assign opcode  = head_insn[31:26];
  assign funct   = head_insn[5:0];
  assign rt_f    = head_insn[20:16];
  assign rs_addr = REG_AW'(head_insn[25:21]);
  assign rt_addr = REG_AW'(head_insn[20:16]);
  assign rd_addr = REG_AW'(head_insn[15:11]);
  assign imm_s   = {{(DATA_W-16){head_insn[15]}}, head_insn[15:0]};
  assign imm_z   = DATA_W'(head_insn[15:0]);
  assign shamt   = DATA_W'(head_insn[10:6]);
  assign br_tgt  = head_pc + (imm_s << BR_SHIFT);
  assign j_tgt   = (head_pc & ~DATA_W'(32'h0fff_ffff)) | DATA_W'({head_insn[25:0], 2'b00});

  assign gpr_rd_addr_0 = rs_addr;
  assign gpr_rd_addr_1 = rt_addr;

  // Operand select: walk from oldest to youngest so the lowest matching
  // index wins, carrying its load flag with it.
  logic [DATA_W-1:0] op0, op1;
  logic              op0_ld, op1_ld;

  always_comb begin
    op0    = gpr_rd_data_0;
    op1    = gpr_rd_data_1;
    op0_ld = 1'b0;
    op1_ld = 1'b0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (fwd_en[k] && !fwd_we_[k] && fwd_addr[k*REG_AW +: REG_AW] == rs_addr) begin
        op0    = fwd_data[k*DATA_W +: DATA_W];
        op0_ld = fwd_is_load[k];
      end
      if (fwd_en[k] && !fwd_we_[k] && fwd_addr[k*REG_AW +: REG_AW] == rt_addr) begin
        op1    = fwd_data[k*DATA_W +: DATA_W];
        op1_ld = fwd_is_load[k];
      end
    end
    if (rs_addr == '0) begin
      op0    = '0;
      op0_ld = 1'b0;
    end
    if (rt_addr == '0) begin
      op1    = '0;
      op1_ld = 1'b0;
    end
  end

  assign ld_hazard = head_valid && (op0_ld || op1_ld);

  logic [3:0]        d_alu, d_mem;
  logic [1:0]        d_exp;
  logic [DATA_W-1:0] d_in0, d_in1, d_wdata, d_br_addr;
  logic [REG_AW-1:0] d_dst;
  logic              d_we_, d_taken, undef;
  logic              op0_ltz, op0_eqz;

  assign op0_ltz = op0[DATA_W-1];
  assign op0_eqz = (op0 == '0);

  always_comb begin
    d_alu     = ALU_NOP;
    d_mem     = MEM_NOP;
    d_exp     = EXP_NONE;
    d_in0     = op0;
    d_in1     = imm_s;
    d_wdata   = '0;
    d_dst     = rt_addr;
    d_we_     = 1'b1;
    d_taken   = 1'b0;
    d_br_addr = br_tgt;
    undef     = 1'b0;
    case (opcode)
      6'h00: begin
        d_dst = rd_addr;
        d_we_ = 1'b0;
        d_in1 = op1;
        case (funct)
          6'h00: begin d_alu = ALU_SLL; d_in0 = op1; d_in1 = shamt; end
          6'h02: begin d_alu = ALU_SRL; d_in0 = op1; d_in1 = shamt; end
          6'h03: begin d_alu = ALU_SRA; d_in0 = op1; d_in1 = shamt; end
          6'h04: begin d_alu = ALU_SLL; d_in0 = op1; d_in1 = op0; end
          6'h06: begin d_alu = ALU_SRL; d_in0 = op1; d_in1 = op0; end
          6'h07: begin d_alu = ALU_SRA; d_in0 = op1; d_in1 = op0; end
          6'h20: d_alu = ALU_ADD;
          6'h21: d_alu = ALU_ADDU;
          6'h22: d_alu = ALU_SUB;
          6'h23: d_alu = ALU_SUBU;
          6'h24: d_alu = ALU_AND;
          6'h25: d_alu = ALU_OR;
          6'h26: d_alu = ALU_XOR;
          6'h27: d_alu = ALU_NOR;
          6'h2a: d_alu = ALU_SLT;
          6'h2b: d_alu = ALU_SLTU;
          default: undef = 1'b1;
        endcase
      end
      6'h01: begin
        if (rt_f == 5'd0)      d_taken = op0_ltz;
        else if (rt_f == 5'd1) d_taken = !op0_ltz;
        else                   undef = 1'b1;
      end
      6'h02: begin d_taken = 1'b1; d_br_addr = j_tgt; end
      6'h03: begin
        // JAL carries the link value through the ALU as pc+4 + 0.
        d_taken   = 1'b1;
        d_br_addr = j_tgt;
        d_alu     = ALU_ADDU;
        d_in0     = head_pc + DATA_W'(4);
        d_in1     = '0;
        d_dst     = REG_AW'(5'd31);
        d_we_     = 1'b0;
      end
      6'h04: d_taken = (op0 == op1);
      6'h05: d_taken = (op0 != op1);
      6'h06: d_taken = op0_ltz || op0_eqz;
      6'h07: d_taken = !op0_ltz && !op0_eqz;
      6'h08: begin d_alu = ALU_ADD;  d_we_ = 1'b0; end
      6'h09: begin d_alu = ALU_ADDU; d_we_ = 1'b0; end
      6'h0c: begin d_alu = ALU_AND;  d_we_ = 1'b0; d_in1 = imm_z; end
      6'h0d: begin d_alu = ALU_OR;   d_we_ = 1'b0; d_in1 = imm_z; end
      6'h0e: begin d_alu = ALU_XOR;  d_we_ = 1'b0; d_in1 = imm_z; end
      6'h20: begin d_alu = ALU_ADDU; d_mem = MEM_LB;  d_we_ = 1'b0; end
      6'h21: begin d_alu = ALU_ADDU; d_mem = MEM_LH;  d_we_ = 1'b0; end
      6'h23: begin d_alu = ALU_ADDU; d_mem = MEM_LW;  d_we_ = 1'b0; end
      6'h24: begin d_alu = ALU_ADDU; d_mem = MEM_LBU; d_we_ = 1'b0; end
      6'h25: begin d_alu = ALU_ADDU; d_mem = MEM_LHU; d_we_ = 1'b0; end
      6'h28: begin d_alu = ALU_ADDU; d_mem = MEM_SB; d_wdata = op1; end
      6'h29: begin d_alu = ALU_ADDU; d_mem = MEM_SH; d_wdata = op1; end
      6'h2b: begin d_alu = ALU_ADDU; d_mem = MEM_SW; d_wdata = op1; end
      default: undef = 1'b1;
    endcase
    if (undef) begin
      d_alu   = ALU_NOP;
      d_mem   = MEM_NOP;
      d_exp   = EXP_UNDEFINSN;
      d_we_   = 1'b1;
      d_taken = 1'b0;
      d_in0   = '0;
      d_in1   = '0;
      d_wdata = '0;
      d_dst   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= if_pc;
      insn_mem[wr_ptr] <= if_insn;
    end
  end

  // A popped taken branch drops everything behind it, including a word
  // written on the same edge, so the buffer simply restarts empty.
  always_ff @(posedge clk) begin
    if (reset || flush || (pop && d_taken)) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush || (!ex_stall && !pop)) begin
      id_valid       <= 1'b0;
      id_pc          <= '0;
      id_alu_op      <= ALU_NOP;
      id_mem_op      <= MEM_NOP;
      id_exp_code    <= EXP_NONE;
      id_alu_in_0    <= '0;
      id_alu_in_1    <= '0;
      id_mem_wr_data <= '0;
      id_dst_addr    <= '0;
      id_gpr_we_     <= 1'b1;
      id_br_taken    <= 1'b0;
      id_br_addr     <= '0;
    end else if (pop) begin
      id_valid       <= 1'b1;
      id_pc          <= head_pc;
      id_alu_op      <= d_alu;
      id_mem_op      <= d_mem;
      id_exp_code    <= d_exp;
      id_alu_in_0    <= d_in0;
      id_alu_in_1    <= d_in1;
      id_mem_wr_data <= d_wdata;
      id_dst_addr    <= d_dst;
      id_gpr_we_     <= d_we_;
      id_br_taken    <= d_taken;
      id_br_addr     <= d_br_addr;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with default parameters.
module tb_decode_stage;

  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_ADDU = 4'd2, ALU_SUB = 4'd3,
                         ALU_AND = 4'd5, ALU_SLL = 4'd11, ALU_SRA = 4'd13;
  localparam logic [3:0] MEM_NOP = 4'd0, MEM_LBU = 4'd2, MEM_LW = 4'd5, MEM_SB = 4'd6,
                         MEM_SW = 4'd8;

  logic        clk, reset;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_insn;
  logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1;
  logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
  logic [1:0]  fwd_en, fwd_we_, fwd_is_load;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;
  logic        ex_stall, flush;
  logic        id_valid, id_gpr_we_, id_br_taken, ld_hazard;
  logic [31:0] id_pc, id_alu_in_0, id_alu_in_1, id_mem_wr_data, id_br_addr;
  logic [3:0]  id_alu_op, id_mem_op;
  logic [1:0]  id_exp_code;
  logic [4:0]  id_dst_addr;

  logic [31:0] regs [32];
  int n_chk, n_fail;

  decode_stage dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_insn(if_insn),
    .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
    .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
    .fwd_en(fwd_en), .fwd_we_(fwd_we_), .fwd_is_load(fwd_is_load),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .ex_stall(ex_stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_alu_op(id_alu_op), .id_mem_op(id_mem_op),
    .id_exp_code(id_exp_code), .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
    .id_mem_wr_data(id_mem_wr_data), .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_),
    .id_br_taken(id_br_taken), .id_br_addr(id_br_addr), .ld_hazard(ld_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    gpr_rd_data_0 = regs[gpr_rd_addr_0];
    gpr_rd_data_1 = regs[gpr_rd_addr_1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_ins(int rs, int rt, int rd, int sh, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ins(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic clear_fwd();
    fwd_en = '0; fwd_we_ = '1; fwd_is_load = '0; fwd_addr = '0; fwd_data = '0;
  endtask

  task automatic run_one(input string tag, input logic [31:0] pc, input logic [31:0] insn,
                         input logic [3:0] alu, input logic [3:0] mem, input logic [1:0] exc,
                         input logic we_n, input logic taken, input logic ops,
                         input logic [31:0] in0, input logic [31:0] in1,
                         input logic [31:0] wdata, input logic [31:0] br, input logic [4:0] dst);
    if_valid = 1'b1; if_pc = pc; if_insn = insn;
    step();
    if_valid = 1'b0;
    step();
    chk({tag, ".valid"}, id_valid, 1);
    chk({tag, ".pc"}, id_pc, pc);
    chk({tag, ".alu"}, id_alu_op, alu);
    chk({tag, ".mem"}, id_mem_op, mem);
    chk({tag, ".exp"}, id_exp_code, exc);
    chk({tag, ".we_"}, id_gpr_we_, we_n);
    chk({tag, ".taken"}, id_br_taken, taken);
    if (ops) begin
      chk({tag, ".in0"}, id_alu_in_0, in0);
      chk({tag, ".in1"}, id_alu_in_1, in1);
    end
    if (!we_n) chk({tag, ".dst"}, id_dst_addr, dst);
    if (taken) chk({tag, ".br_addr"}, id_br_addr, br);
    if (mem >= MEM_SB) chk({tag, ".wdata"}, id_mem_wr_data, wdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[1] = 32'd3; regs[2] = 32'd77; regs[5] = 32'd3; regs[6] = 32'd4;
    regs[12] = 32'h8000_0000;
    reset = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    if_valid = 1'b0; if_pc = '0; if_insn = '0;
    clear_fwd();
    step(); step();
    reset = 1'b0;
    chk("rst.valid", id_valid, 0);
    chk("rst.if_ready", if_ready, 1);
    chk("rst.we_", id_gpr_we_, 1);
    chk("rst.pc", id_pc, 0);
    chk("rst.br_addr", id_br_addr, 0);

    // ADDI r2,r0,5 then ADD r3,r2,r2 with r2 forwarded from stage 0
    if_valid = 1'b1; if_pc = 32'h0; if_insn = i_ins(8, 0, 2, 5);
    step();
    if_pc = 32'h4; if_insn = r_ins(2, 2, 3, 0, 32'h20);
    step();
    if_valid = 1'b0;
    chk("addi.valid", id_valid, 1);
    chk("addi.in0", id_alu_in_0, 0);
    chk("addi.in1", id_alu_in_1, 5);
    chk("addi.dst", id_dst_addr, 2);
    chk("addi.we_", id_gpr_we_, 0);
    fwd_en = 2'b01; fwd_we_ = 2'b10; fwd_addr = {5'd0, 5'd2}; fwd_data = {32'd0, 32'd5};
    step();
    chk("fwd.in0", id_alu_in_0, 5);
    chk("fwd.in1", id_alu_in_1, 5);
    chk("fwd.dst", id_dst_addr, 3);
    chk("fwd.alu", id_alu_op, ALU_ADD);
    clear_fwd();

    // younger load match on r4 beats older non-load match
    fwd_en = 2'b11; fwd_we_ = 2'b00; fwd_is_load = 2'b01;
    fwd_addr = {5'd4, 5'd4}; fwd_data = {32'd9, 32'd111};
    if_valid = 1'b1; if_pc = 32'h10; if_insn = r_ins(4, 0, 13, 0, 32'h20);
    step();
    if_valid = 1'b0;
    #1;
    chk("ldhz.hazard", ld_hazard, 1);
    step();
    chk("ldhz.bubble0", id_valid, 0);
    step();
    chk("ldhz.bubble1", id_valid, 0);
    fwd_is_load = 2'b00; fwd_data = {32'd9, 32'd42};
    #1;
    chk("ldhz.clear", ld_hazard, 0);
    step();
    chk("ldhz.valid", id_valid, 1);
    chk("ldhz.pc", id_pc, 32'h10);
    chk("ldhz.in0", id_alu_in_0, 42);
    clear_fwd();

    // fill the buffer while stalled
    ex_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_valid = 1'b1; if_pc = 32'h200 + 32'(4 * i); if_insn = i_ins(9, 0, 16 + i, i + 1);
      step();
    end
    chk("full.if_ready", if_ready, 0);
    if_pc = 32'h210; if_insn = i_ins(9, 0, 20, 99);
    step();
    chk("full.if_ready2", if_ready, 0);
    if_valid = 1'b0; ex_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain.valid", id_valid, 1);
      chk("drain.pc", id_pc, 32'h200 + 32'(4 * i));
      chk("drain.in1", id_alu_in_1, 32'(i + 1));
    end
    step();
    chk("drain.empty", id_valid, 0);

    // BNE not taken, then BNE taken drops the younger entries
    ex_stall = 1'b1;
    if_valid = 1'b1; if_pc = 32'hfc;  if_insn = i_ins(5, 1, 5, 8); step();
    if_pc = 32'h100; if_insn = i_ins(5, 1, 6, 8); step();
    if_pc = 32'h104; if_insn = i_ins(9, 0, 7, 7); step();
    ex_stall = 1'b0;
    if_pc = 32'h108; if_insn = i_ins(9, 0, 8, 8);
    step();
    chk("bne0.valid", id_valid, 1);
    chk("bne0.pc", id_pc, 32'hfc);
    chk("bne0.taken", id_br_taken, 0);
    if_pc = 32'h10c; if_insn = i_ins(9, 0, 9, 9);
    step();
    if_valid = 1'b0;
    chk("bne1.pc", id_pc, 32'h100);
    chk("bne1.taken", id_br_taken, 1);
    chk("bne1.br_addr", id_br_addr, 32'h108);
    chk("bne1.if_ready", if_ready, 1);
    step();
    chk("bne.dropped", id_valid, 0);
    chk("bne.taken_once", id_br_taken, 0);

    // flush with three buffered entries under stall
    if_valid = 1'b1; if_pc = 32'h800; if_insn = i_ins(9, 0, 7, 7); step();
    if_valid = 1'b0; step();
    ex_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      if_valid = 1'b1; if_pc = 32'h800 + 32'(4 * i); if_insn = i_ins(9, 0, 7, i); step();
    end
    chk("flush.held_valid", id_valid, 1);
    chk("flush.held_pc", id_pc, 32'h800);
    flush = 1'b1;
    step();
    chk("flush.valid", id_valid, 0);
    chk("flush.if_ready", if_ready, 1);
    flush = 1'b0; if_valid = 1'b0; ex_stall = 1'b0;
    step();
    chk("flush.empty", id_valid, 0);

    // reset with three buffered entries under stall
    if_valid = 1'b1; if_pc = 32'h840; if_insn = i_ins(9, 0, 7, 7); step();
    if_valid = 1'b0; step();
    ex_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      if_valid = 1'b1; if_pc = 32'h840 + 32'(4 * i); if_insn = i_ins(9, 0, 7, i); step();
    end
    reset = 1'b1;
    step();
    chk("mrst.valid", id_valid, 0);
    chk("mrst.if_ready", if_ready, 1);
    chk("mrst.pc", id_pc, 0);
    reset = 1'b0; if_valid = 1'b0; ex_stall = 1'b0;
    step();
    chk("mrst.empty", id_valid, 0);

    // directed decode vectors
    run_one("sub",   32'h900, r_ins(6, 1, 13, 0, 32'h22), ALU_SUB, MEM_NOP, 2'd0, 0, 0, 1,
            32'd4, 32'd3, 0, 0, 5'd13);
    run_one("sll",   32'h904, r_ins(0, 6, 10, 3, 0), ALU_SLL, MEM_NOP, 2'd0, 0, 0, 1,
            32'd4, 32'd3, 0, 0, 5'd10);
    run_one("srav",  32'h908, r_ins(1, 12, 10, 0, 7), ALU_SRA, MEM_NOP, 2'd0, 0, 0, 1,
            32'h8000_0000, 32'd3, 0, 0, 5'd10);
    run_one("addi",  32'h90c, i_ins(8, 6, 14, -2), ALU_ADD, MEM_NOP, 2'd0, 0, 0, 1,
            32'd4, 32'hffff_fffe, 0, 0, 5'd14);
    run_one("andi",  32'h910, i_ins(12, 6, 11, 32'hffff), ALU_AND, MEM_NOP, 2'd0, 0, 0, 1,
            32'd4, 32'h0000_ffff, 0, 0, 5'd11);
    run_one("lw",    32'h914, i_ins(35, 1, 9, 16), ALU_ADDU, MEM_LW, 2'd0, 0, 0, 1,
            32'd3, 32'd16, 0, 0, 5'd9);
    run_one("lbu",   32'h918, i_ins(36, 1, 9, -1), ALU_ADDU, MEM_LBU, 2'd0, 0, 0, 1,
            32'd3, 32'hffff_ffff, 0, 0, 5'd9);
    run_one("sw",    32'h91c, i_ins(43, 1, 6, -4), ALU_ADDU, MEM_SW, 2'd0, 1, 0, 1,
            32'd3, 32'hffff_fffc, 32'd4, 0, 5'd0);
    run_one("beq",   32'h500, i_ins(4, 1, 5, 16), ALU_NOP, MEM_NOP, 2'd0, 1, 1, 0,
            0, 0, 0, 32'h510, 5'd0);
    run_one("bgtz",  32'h600, i_ins(7, 12, 0, 4), ALU_NOP, MEM_NOP, 2'd0, 1, 0, 0,
            0, 0, 0, 0, 5'd0);
    run_one("bltz",  32'h700, i_ins(1, 12, 0, -16), ALU_NOP, MEM_NOP, 2'd0, 1, 1, 0,
            0, 0, 0, 32'h6f0, 5'd0);
    run_one("blez",  32'h920, i_ins(6, 0, 0, 8), ALU_NOP, MEM_NOP, 2'd0, 1, 1, 0,
            0, 0, 0, 32'h928, 5'd0);
    run_one("jal",   32'h400, {6'h03, 26'h40}, ALU_ADDU, MEM_NOP, 2'd0, 0, 1, 1,
            32'h404, 32'd0, 0, 32'h100, 5'd31);
    run_one("undef", 32'h300, {6'h3f, 26'h0}, ALU_NOP, MEM_NOP, 2'd1, 1, 0, 0,
            0, 0, 0, 0, 5'd0);
    run_one("undef_fn", 32'h304, r_ins(1, 1, 1, 0, 32'h3f), ALU_NOP, MEM_NOP, 2'd1, 1, 0, 0,
            0, 0, 0, 0, 5'd0);

    // r0 is never forwarded and never raises a load hazard
    fwd_en = 2'b01; fwd_we_ = 2'b10; fwd_is_load = 2'b01; fwd_addr = '0;
    fwd_data = {32'd0, 32'hdead};
    run_one("zero_fwd", 32'h930, r_ins(0, 6, 13, 0, 32'h20), ALU_ADD, MEM_NOP, 2'd0, 0, 0, 1,
            32'd0, 32'd4, 0, 0, 5'd13);
    clear_fwd();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
